// File: rtl/lsu_axi_port.sv
// Load/store unit bridging the execute stage to an AXI data master port.
// One op in flight; handles lane alignment, strobes, load extension, bus errors and a watchdog.
module lsu_axi_port #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] axi_AW_ADDR,
  output logic              axi_AW_VALID,
  input  logic              axi_AW_READY,
  output logic [XLEN-1:0]   axi_W_DATA,
  output logic [XLEN/8-1:0] axi_W_STRB,
  output logic              axi_W_VALID,
  input  logic              axi_W_READY,
  input  logic              axi_B_VALID,
  input  logic [1:0]        axi_B_RESP,
  output logic              axi_B_READY,
  output logic [ADDR_W-1:0] axi_AR_ADDR,
  output logic              axi_AR_VALID,
  input  logic              axi_AR_READY,
  input  logic [XLEN-1:0]   axi_R_DATA,
  input  logic [1:0]        axi_R_RESP,
  input  logic              axi_R_VALID,
  output logic              axi_R_READY
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP} state_t;

  typedef struct packed {
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [1:0]        size;
    logic              uns;
  } req_t;

  state_t          state, state_n;
  req_t            req_q;
  logic            aw_done, w_done;
  logic [TW-1:0]   timer;
  logic            to_hit, tmo, bad;
  logic [2:0]      amask;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] sh;

  // Truncate the shifted read word to the access size, then extend.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] mask;
    logic            sgn;
    case (sz)
      2'd0:    begin mask = XLEN'(8'hFF);         sgn = d[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sgn = d[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sgn = d[31];     end
      default: begin mask = '1;                   sgn = d[XLEN-1]; end
    endcase
    return (d & mask) | ((sgn && !uns) ? ~mask : '0);
  endfunction

  assign amask  = 3'((4'd1 << req_size) - 4'd1);
  assign bad    = ((XLEN == 32) && (req_size == 2'd3)) || ((req_addr[2:0] & amask) != 3'd0);
  assign to_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign off    = req_q.addr[OFFW-1:0];
  assign sh     = axi_R_DATA >> (8 * off);

  assign axi_AW_ADDR = req_q.addr;
  assign axi_AR_ADDR = req_q.addr;
  assign axi_W_DATA  = req_q.wdata << (8 * off);

  for (genvar i = 0; i < NB; i++) begin : g_strb
    assign axi_W_STRB[i] = (i >= int'(off)) && (i < int'(off) + (1 << req_q.size));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Completion is tested before the watchdog so a same-cycle handshake wins.
  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    case (state)
      IDLE:    if (req_valid) state_n = bad ? RESP : (req_store ? WR_AW_W : RD_AR);
      RD_AR:   if (axi_AR_READY) state_n = RD_R;
               else if (to_hit) begin state_n = RESP; tmo = 1'b1; end
      RD_R:    if (axi_R_VALID) state_n = RESP;
               else if (to_hit) begin state_n = RESP; tmo = 1'b1; end
      WR_AW_W: if ((aw_done || axi_AW_READY) && (w_done || axi_W_READY)) state_n = WR_B;
               else if (to_hit) begin state_n = RESP; tmo = 1'b1; end
      WR_B:    if (axi_B_VALID) state_n = RESP;
               else if (to_hit) begin state_n = RESP; tmo = 1'b1; end
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    axi_AR_VALID = 1'b0;
    axi_R_READY  = 1'b0;
    axi_AW_VALID = 1'b0;
    axi_W_VALID  = 1'b0;
    axi_B_READY  = 1'b0;
    case (state)
      IDLE:    req_ready    = 1'b1;
      RD_AR:   axi_AR_VALID = 1'b1;
      RD_R:    axi_R_READY  = 1'b1;
      WR_AW_W: begin
        axi_AW_VALID = !aw_done;
        axi_W_VALID  = !w_done;
      end
      WR_B:    axi_B_READY  = 1'b1;
      RESP:    rsp_valid    = 1'b1;
      default: ;
    endcase
  end

  // Timer restarts on every state change, so each wait state gets its own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer <= '0;
    else if (state_n != state)  timer <= '0;
    else if (state inside {RD_AR, RD_R, WR_AW_W, WR_B}) timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q     <= '{store: req_store, addr: req_addr, wdata: req_wdata,
                         size: req_size, uns: req_unsigned};
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= bad ? ERR_ALIGN : ERR_OK;
        end
        RD_R: if (axi_R_VALID) begin
          rsp_err   <= (axi_R_RESP != 2'd0) ? ERR_BUS : ERR_OK;
          rsp_rdata <= (axi_R_RESP != 2'd0) ? '0 : extend(sh, req_q.size, req_q.uns);
        end
        WR_AW_W: begin
          aw_done <= aw_done | axi_AW_READY;
          w_done  <= w_done  | axi_W_READY;
        end
        WR_B: if (axi_B_VALID) rsp_err <= (axi_B_RESP != 2'd0) ? ERR_BUS : ERR_OK;
        default: ;
      endcase
      if (tmo) begin
        rsp_err   <= ERR_TMO;
        rsp_rdata <= '0;
      end
    end
  end
endmodule
